// File: rtl/add_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_pkg
// Description : Shared state encoding and sizing helpers for the add_serial
//               multi-cycle adder.
// Revision    : 1.0 - initial release
// ============================================================================
package add_serial_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;

    localparam state_t c_idle = 2'd0;
    localparam state_t c_run  = 2'd1;
    localparam state_t c_done = 2'd2;

    // Number of RUN cycles needed to cover all WIDTH bits, DIGIT bits at a time
    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width for a value range 0..value-1; never narrower than one bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_serial_fa_digit.sv
`default_nettype none
// ============================================================================
// Module      : fa_digit
// Description : Combinational DIGIT-bit ripple adder built from full-adder
//               equations; one slice reused every cycle by add_serial.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_digit
    import add_serial_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = c_in;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            assign s_d[i]   = a_d[i] ^ b_d[i] ^ w_c[i];
            assign w_c[i+1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
        end
    endgenerate

    assign c_out = w_c[DIGIT];

endmodule
`default_nettype wire

// File: rtl/add_serial.sv
`default_nettype none
// ============================================================================
// Module      : add_serial
// Description : Multi-cycle N-bit adder. Adds a + b + ci DIGIT bits per
//               clock, LSB first, with valid/ready handshakes on both sides.
//               Optional subtract mode enabled by macro ADD_SERIAL_SUB_EN
//               (adds the sub port; sub=1 computes a + ~b + 1).
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CNT_W = clog2(STEPS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(STEPS - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("add_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [DIGIT-1:0] w_a_d;
    logic [DIGIT-1:0] w_b_d;
    logic [DIGIT-1:0] w_s_d;
    logic             w_c_out;

    // Operand conditioning at capture: subtraction folds into a + ~b + 1
    always_comb begin
        w_b_in = b;
        w_c_in = ci;
`ifdef ADD_SERIAL_SUB_EN
        if (sub) begin
            w_b_in = ~b;
            w_c_in = 1'b1;
        end
`endif
    end

    // Select the digit currently being processed from the captured operands
    always_comb begin
        w_a_d = r_a[int'(r_cnt) * DIGIT +: DIGIT];
        w_b_d = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    end

    fa_digit #(
        .DIGIT (DIGIT)
    ) u_fa_digit (
        .a_d   (w_a_d),
        .b_d   (w_b_d),
        .c_in  (r_carry),
        .s_d   (w_s_d),
        .c_out (w_c_out)
    );

    // Handshake FSM, digit counter, operand capture, carry and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_s     <= '0;
                        r_cnt   <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_s[int'(r_cnt) * DIGIT +: DIGIT] <= w_s_d;
                    r_carry <= w_c_out;
                    if (r_cnt == c_last) begin
                        r_co    <= w_c_out;
                        r_state <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // in_ready is the only output that looks at rst directly, so it is never
    // high during reset; everything else decodes registered state only
    assign in_ready  = (r_state == c_idle) && !rst;
    assign out_valid = (r_state == c_done);
    assign busy      = (r_state == c_run) || (r_state == c_done);
    assign s         = r_s;
    assign co        = r_co;

endmodule
`default_nettype wire
